// File: rtl/select_sweep_pkg.sv
// Shared types and constants for the select_sweep exhaustive selector checker.
// FSM state encoding, golden-model branch codes and the vector-count helper.
package select_sweep_pkg;

    localparam int unsigned BR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [BR_W-1:0] BR_MAX = 2'd0;
    localparam logic [BR_W-1:0] BR_CD  = 2'd1;
    localparam logic [BR_W-1:0] BR_SUM = 2'd2;

    // Number of operand combinations for four operands of the given width.
    function automatic int unsigned vec_count(input int unsigned width);
        return 32'd1 << (4 * width);
    endfunction

endpackage

// File: rtl/select_ref_model.sv
// Combinational golden model of the 2-bit priority selector.
// Produces the expected result and which priority branch produced it.
module select_ref_model
    import select_sweep_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] exp_c,
    output logic [BR_W-1:0]  br_c
);

    // Priority order: max branch, then c>d, otherwise carry-less sum.
    always_comb begin
        exp_c = WIDTH'(a + b);
        br_c  = BR_SUM;
        if ((a > b) || (c < d)) begin
            exp_c = a;
            br_c  = BR_MAX;
        end else if (c > d) begin
            exp_c = c;
            br_c  = BR_CD;
        end
    end

endmodule

// File: rtl/select_sweep.sv
// Exhaustive stimulus driver and checker for the priority selector.
// Optional SELECT_SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module select_sweep
    import select_sweep_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNT_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     c,
    output logic [WIDTH-1:0]     d,
    input  logic [WIDTH-1:0]     z,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     hit0,
    output logic [CNT_W-1:0]     hit1,
    output logic [CNT_W-1:0]     hit2,
    output logic [CNT_W-1:0]     mismatch,
    output logic [4*WIDTH-1:0]   fail_idx
);

    localparam int unsigned      IDX_W    = 4 * WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(vec_count(WIDTH) - 32'd1);

`ifdef SELECT_SWEEP_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] hit0_q, hit0_d;
    logic [CNT_W-1:0] hit1_q, hit1_d;
    logic [CNT_W-1:0] hit2_q, hit2_d;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;

    logic [WIDTH-1:0] exp_c;
    logic [BR_W-1:0]  br_c;
    logic             start_ok_c;
    logic             mismatch_c;
    logic             stop_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    select_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .a     (idx_q[WIDTH-1:0]),
        .b     (idx_q[2*WIDTH-1:WIDTH]),
        .c     (idx_q[3*WIDTH-1:2*WIDTH]),
        .d     (idx_q[4*WIDTH-1:3*WIDTH]),
        .exp_c (exp_c),
        .br_c  (br_c)
    );

    // Sweep control: start only honoured when not mid-sweep.
    assign start_ok_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign mismatch_c = (z != exp_c);
    assign stop_c     = (idx_q == IDX_LAST) || (STOP_ON_ERR && mismatch_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_DRIVE;
            ST_DRIVE:  state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = stop_c ? ST_DONE : ST_DRIVE;
            ST_DONE:   if (start) state_d = ST_DRIVE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: operands, counters, sticky error capture.
    always_comb begin
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        hit0_d     = hit0_q;
        hit1_d     = hit1_q;
        hit2_d     = hit2_q;
        mis_d      = mis_q;
        fail_idx_d = fail_idx_q;
        if (start_ok_c) begin
            idx_d      = '0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            hit0_d     = '0;
            hit1_d     = '0;
            hit2_d     = '0;
            mis_d      = '0;
            fail_idx_d = '0;
        end else if (state_q == ST_SAMPLE) begin
            case (br_c)
                BR_MAX:  hit0_d = sat_inc(hit0_q);
                BR_CD:   hit1_d = sat_inc(hit1_q);
                default: hit2_d = sat_inc(hit2_q);
            endcase
            if (mismatch_c) begin
                mis_d = sat_inc(mis_q);
                if (!err_q) begin
                    err_d      = 1'b1;
                    fail_idx_d = idx_q;
                end
            end
            if (stop_c) begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hit0_q     <= '0;
            hit1_q     <= '0;
            hit2_q     <= '0;
            mis_q      <= '0;
            fail_idx_q <= '0;
        end else begin
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            hit0_q     <= hit0_d;
            hit1_q     <= hit1_d;
            hit2_q     <= hit2_d;
            mis_q      <= mis_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    // Operands come straight from the index register so they hold after the sweep.
    assign a        = idx_q[WIDTH-1:0];
    assign b        = idx_q[2*WIDTH-1:WIDTH];
    assign c        = idx_q[3*WIDTH-1:2*WIDTH];
    assign d        = idx_q[4*WIDTH-1:3*WIDTH];
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign hit0     = hit0_q;
    assign hit1     = hit1_q;
    assign hit2     = hit2_q;
    assign mismatch = mis_q;
    assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_select_sweep.sv
// Self-checking bench for select_sweep: behavioural selectors drive z, and
// expected counts come from a vector-by-vector walk of the selection rules.
module tb_select_sweep;

    localparam int W    = 2;
    localparam int CW   = 9;
    localparam int BASE = 1 << W;
    localparam int NV   = 1 << (4 * W);
    localparam int BUDGET = 700;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a, b, c, d, z;
    logic           busy, done, err;
    logic [CW-1:0]  hit0, hit1, hit2, mismatch;
    logic [4*W-1:0] fail_idx;

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    int mask [NV];

    always #5 clk = ~clk;

    select_sweep #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .z        (z),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .hit0     (hit0),
        .hit1     (hit1),
        .hit2     (hit2),
        .mismatch (mismatch),
        .fail_idx (fail_idx)
    );

    function automatic int op(input int v, input int k);
        return (v / (BASE ** k)) % BASE;
    endfunction

    function automatic int gold_br(input int v);
        if (op(v, 0) > op(v, 1) || op(v, 2) < op(v, 3)) return 0;
        if (op(v, 2) > op(v, 3)) return 1;
        return 2;
    endfunction

    function automatic int gold_val(input int v);
        case (gold_br(v))
            0:       return op(v, 0);
            1:       return op(v, 2);
            default: return (op(v, 0) + op(v, 1)) % BASE;
        endcase
    endfunction

    // Selector variants: 0 correct, 1 tied low, 2 carry kept, 3 c in sum branch, 4 random faults.
    function automatic int sel_val(input int m, input int v);
        case (m)
            1:       return 0;
            2:       return (gold_br(v) == 2) ? op(v, 0) + op(v, 1) : gold_val(v);
            3:       return (gold_br(v) == 2) ? op(v, 2) : gold_val(v);
            4:       return gold_val(v) ^ mask[v];
            default: return gold_val(v);
        endcase
    endfunction

    always_comb z = W'(sel_val(mode, int'({d, c, b, a})));

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({d, c, b, a} !== '0) begin
            bad++; $display("FAIL reset_operands: got %0h want 0", {d, c, b, a});
        end
        total++;
        if ({busy, done, err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, err});
        end
        total++;
        if ({hit0, hit1, hit2, mismatch, fail_idx} !== '0) begin
            bad++; $display("FAIL reset_counters: got %0d/%0d/%0d/%0d/%0d want 0", hit0, hit1, hit2, mismatch, fail_idx);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++; $display("FAIL idle_no_start: got busy,done=%b want 00", {busy, done});
        end
    endtask

    // Runs one sweep against selector variant m; hold_start keeps start high throughout.
    task automatic test_sweep(input int m, input string name, input bit hold_start);
        int  e_last, e_mis, e_fidx, cyc, walk_err, zv;
        int  e_h [3];
        bit  stop_en;
`ifdef SELECT_SWEEP_STOP_ON_ERR_EN
        stop_en = 1'b1;
`else
        stop_en = 1'b0;
`endif
        e_last = NV - 1; e_mis = 0; e_fidx = 0; e_h = '{0, 0, 0};
        for (int v = 0; v < NV; v++) begin
            zv = sel_val(m, v) % BASE;
            e_h[gold_br(v)]++;
            if (zv != gold_val(v)) begin
                if (e_mis == 0) e_fidx = v;
                e_mis++;
                if (stop_en) begin
                    e_last = v;
                    break;
                end
            end
        end

        mode = m;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = hold_start;
        cyc = 1;
        walk_err = 0;
        total++;
        if (busy !== 1'b1 || {d, c, b, a} !== '0 || {done, err, mismatch, hit0, hit1, hit2} !== '0) begin
            bad++; $display("FAIL %s_start: busy=%b ops=%0h done=%b err=%b want busy=1 ops=0 cleared", name, busy, {d, c, b, a}, done, err);
        end
        while (done !== 1'b1 && cyc < BUDGET) begin
            if ({d, c, b, a} !== 8'((cyc - 1) / 2) || busy !== 1'b1) walk_err++;
            if (cyc == 2) begin
                total++;
                if (hit2 !== '0) begin
                    bad++; $display("FAIL %s_cnt_early: hit2=%0d want 0", name, hit2);
                end
            end
            if (cyc == 3) begin
                total++;
                if (hit2 !== CW'(1)) begin
                    bad++; $display("FAIL %s_cnt_latency: hit2=%0d want 1", name, hit2);
                end
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== 2 * e_last + 3) begin
            bad++; $display("FAIL %s_done_cycle: got %0d want %0d", name, cyc, 2 * e_last + 3);
        end
        total++;
        if (walk_err !== 0) begin
            bad++; $display("FAIL %s_walk: %0d cycles with wrong operands or busy, want 0", name, walk_err);
        end
        if (hold_start) return;
        total++;
        if (busy !== 1'b0 || err !== (e_mis > 0)) begin
            bad++; $display("FAIL %s_flags: busy=%b err=%b want busy=0 err=%b", name, busy, err, e_mis > 0);
        end
        total++;
        if (mismatch !== CW'(e_mis)) begin
            bad++; $display("FAIL %s_mismatch: got %0d want %0d", name, mismatch, e_mis);
        end
        total++;
        if (hit0 !== CW'(e_h[0]) || hit1 !== CW'(e_h[1]) || hit2 !== CW'(e_h[2])) begin
            bad++; $display("FAIL %s_hits: got %0d/%0d/%0d want %0d/%0d/%0d", name, hit0, hit1, hit2, e_h[0], e_h[1], e_h[2]);
        end
        if (e_mis > 0) begin
            total++;
            if (fail_idx !== 8'(e_fidx)) begin
                bad++; $display("FAIL %s_fail_idx: got %0d want %0d", name, fail_idx, e_fidx);
            end
        end
        total++;
        if ({d, c, b, a} !== 8'(e_last)) begin
            bad++; $display("FAIL %s_hold_last: got %0d want %0d", name, {d, c, b, a}, e_last);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = $urandom_range(80, 120);
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (n) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({d, c, b, a, busy, done, err} !== '0 || {hit0, hit1, hit2, mismatch, fail_idx} !== '0) begin
            bad++; $display("FAIL async_reset: ops=%0h busy=%b done=%b hits=%0d/%0d/%0d want all 0", {d, c, b, a}, busy, done, hit0, hit1, hit2);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00 || {d, c, b, a} !== '0) begin
            bad++; $display("FAIL no_resume: busy=%b done=%b ops=%0h want 0", busy, done, {d, c, b, a});
        end
        test_sweep(0, "after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        test_sweep(1, "pre_restart", 1'b0);
        test_sweep(0, "held_start", 1'b1);
        @(negedge clk);
        total++;
        if ({done, err, busy} !== 3'b001 || {hit0, hit1, hit2, mismatch} !== '0 || {d, c, b, a} !== '0) begin
            bad++; $display("FAIL restart_in_done: done=%b err=%b busy=%b mis=%0d want done=0 err=0 busy=1 cleared", done, err, busy, mismatch);
        end
        start = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int v = 0; v < NV; v++)
            mask[v] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, BASE - 1)) : 0;
        test_reset();
        test_sweep(0, "correct", 1'b0);
        test_sweep(1, "tied_zero", 1'b0);
        test_sweep(2, "carry_kept", 1'b0);
        test_sweep(3, "c_in_sum", 1'b0);
        test_sweep(4, "random_fault", 1'b0);
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
